// File: rtl/decode_pkg.sv
// Shared types and helpers for the RV32 decode stage: opcodes, format codes,
// the decoded-field bundle, format classification and immediate generation.
package decode_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned IMM_MAX_W = 64;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_UNK = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [6:0] funct7;
        fmt_e       fmt;
        logic       illegal;
    } dec_bundle_t;

    function automatic fmt_e fmt_of(input logic [6:0] opcode);
        fmt_e f;
        case (opcode)
            OPC_LUI, OPC_AUIPC:                                      f = FMT_U;
            OPC_JAL:                                                 f = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_MISC_MEM, OPC_SYSTEM: f = FMT_I;
            OPC_STORE:                                               f = FMT_S;
            OPC_BRANCH:                                              f = FMT_B;
            OPC_OP:                                                  f = FMT_R;
            default:                                                 f = FMT_UNK;
        endcase
        return f;
    endfunction

    // Opcode bits never feed an immediate, so only instr[31:7] is taken.
    // Result is sign-extended to the widest XLEN; callers truncate.
    function automatic logic [IMM_MAX_W-1:0] imm_gen(input logic [INSTR_W-1:7] instr,
                                                     input fmt_e fmt);
        logic [IMM_MAX_W-1:0] imm;
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{52{instr[31]}}, instr[31:20]};
            FMT_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            FMT_U:   imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            FMT_J:   imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// Generic 2-entry valid/ready buffer: main register drives the outputs, a skid
// register absorbs one extra beat so in_ready can be a pure register.
module decode_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             in_xfer;
    logic             out_xfer;

    assign in_xfer  = in_valid_i && in_ready_q;
    assign out_xfer = out_valid_q && out_ready_i;

    // Next-state and data movement; flush overrides every other event.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_d  = in_data_i;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d = in_data_i;
                    end else if (in_xfer) begin
                        skid_d  = in_data_i;
                        state_d = ST_TWO;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_q;

endmodule

// File: rtl/decode_stage.sv
// RV32 decode stage: field split, format classification, immediate generation
// and illegal detection ahead of a 2-entry skid buffer. DECODE_STATS_EN adds counters.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_funct7,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
`ifdef DECODE_STATS_EN
    ,
    output logic [31:0]     stat_decoded,
    output logic [31:0]     stat_illegal
`endif
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] imm;
        dec_bundle_t     dec;
    } stage_bundle_t;

    localparam int unsigned BUNDLE_W = $bits(stage_bundle_t);

    fmt_e          in_fmt_c;
    stage_bundle_t in_bundle_c;
    stage_bundle_t out_bundle;

    // Decode on the input side so both buffer entries hold finished bundles.
    always_comb begin
        in_bundle_c            = '0;
        in_fmt_c               = fmt_of(in_instr[6:0]);
        in_bundle_c.pc         = in_pc;
        in_bundle_c.imm        = XLEN'(imm_gen(in_instr[31:7], in_fmt_c));
        in_bundle_c.dec.opcode = in_instr[6:0];
        in_bundle_c.dec.rd     = in_instr[11:7];
        in_bundle_c.dec.funct3 = in_instr[14:12];
        in_bundle_c.dec.rs1    = in_instr[19:15];
        in_bundle_c.dec.rs2    = in_instr[24:20];
        in_bundle_c.dec.funct7 = in_instr[31:25];
        in_bundle_c.dec.fmt    = in_fmt_c;
        in_bundle_c.dec.illegal = (in_instr[1:0] != 2'b11) || (in_fmt_c == FMT_UNK);
    end

    decode_skid_buf #(
        .WIDTH(BUNDLE_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_bundle_c),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_bundle)
    );

    assign out_pc      = out_bundle.pc;
    assign out_imm     = out_bundle.imm;
    assign out_opcode  = out_bundle.dec.opcode;
    assign out_rd      = out_bundle.dec.rd;
    assign out_funct3  = out_bundle.dec.funct3;
    assign out_rs1     = out_bundle.dec.rs1;
    assign out_rs2     = out_bundle.dec.rs2;
    assign out_funct7  = out_bundle.dec.funct7;
    assign out_fmt     = out_bundle.dec.fmt;
    assign out_illegal = out_bundle.dec.illegal;

`ifdef DECODE_STATS_EN
    logic [31:0] stat_decoded_q;
    logic [31:0] stat_illegal_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_decoded_q <= '0;
            stat_illegal_q <= '0;
        end else if (out_valid && out_ready) begin
            stat_decoded_q <= stat_decoded_q + 32'd1;
            if (out_bundle.dec.illegal) begin
                stat_illegal_q <= stat_illegal_q + 32'd1;
            end
        end
    end

    assign stat_decoded = stat_decoded_q;
    assign stat_illegal = stat_illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus randomized traffic
// against a queue-based reference decoder.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_funct7;
    logic [2:0]  out_fmt;
    logic [31:0] out_imm;
    logic        out_illegal;
`ifdef DECODE_STATS_EN
    logic [31:0] stat_decoded;
    logic [31:0] stat_illegal;
`endif

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_opcode (out_opcode),
        .out_rd     (out_rd),
        .out_funct3 (out_funct3),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_funct7 (out_funct7),
        .out_fmt    (out_fmt),
        .out_imm    (out_imm),
        .out_illegal(out_illegal)
`ifdef DECODE_STATS_EN
        ,
        .stat_decoded(stat_decoded),
        .stat_illegal(stat_illegal)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        illegal;
    } obs_t;

    int   n_run  = 0;
    int   n_fail = 0;
    obs_t expq[$];

    // Reference decode: immediates rebuilt with signed arithmetic on the word.
    function automatic obs_t model(input logic [31:0] instr, input logic [31:0] pc);
        obs_t m;
        int   s;
        int   hi;
        int   sign;
        s    = $signed(instr);
        sign = s >>> 31;
        m.pc = pc;
        m.instr = instr;
        case (instr[6:0])
            7'b0110111, 7'b0010111:                                  m.fmt = 3'd4;
            7'b1101111:                                              m.fmt = 3'd5;
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: m.fmt = 3'd1;
            7'b0100011:                                              m.fmt = 3'd2;
            7'b1100011:                                              m.fmt = 3'd3;
            7'b0110011:                                              m.fmt = 3'd0;
            default:                                                 m.fmt = 3'd7;
        endcase
        case (m.fmt)
            3'd1: begin hi = s >>> 20; m.imm = 32'(hi); end
            3'd2: begin hi = s >>> 25; m.imm = 32'(hi) * 32'd32 + 32'(instr[11:7]); end
            3'd3: m.imm = 32'(sign) * 32'd4096 + 32'(instr[7]) * 32'd2048
                          + 32'(instr[30:25]) * 32'd32 + 32'(instr[11:8]) * 32'd2;
            3'd4: m.imm = (instr / 32'd4096) * 32'd4096;
            3'd5: m.imm = 32'(sign) * 32'd1048576 + 32'(instr[19:12]) * 32'd4096
                          + 32'(instr[20]) * 32'd2048 + 32'(instr[30:21]) * 32'd2;
            default: m.imm = 32'd0;
        endcase
        m.illegal = (instr[1:0] != 2'b11) || (m.fmt == 3'd7);
        return m;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.pc      = out_pc;
        o.instr   = {out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode};
        o.fmt     = out_fmt;
        o.imm     = out_imm;
        o.illegal = out_illegal;
        return o;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [0:10];
        logic [31:0] r;
        int          k;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0010011,
                7'b0001111, 7'b1110011, 7'b0100011, 7'b1100011, 7'b0110011};
        r = $urandom;
        k = $urandom_range(0, 13);
        if (k <= 10) r[6:0] = ops[k];
        return r;
    endfunction

    // One clock: book-keep the model, then advance to just after the edge.
    task automatic tick(output bit got, output bit had, output obs_t obs, output obs_t exp);
        bit fl;
        fl  = flush;
        got = out_valid && out_ready && !fl;
        obs = observe();
        had = 1'b0;
        exp = '0;
        if (got && expq.size() > 0) begin
            had = 1'b1;
            exp = expq.pop_front();
        end
        if (in_valid && in_ready && !fl) expq.push_back(model(in_instr, in_pc));
        @(posedge clk);
        #1;
        if (fl) expq.delete();
    endtask

    task automatic drain(input string name, output int n_out);
        bit   got, had, acc;
        obs_t o, e;
        int   cyc;
        n_out = 0;
        cyc   = 0;
        out_ready = 1'b1;
        while ((expq.size() > 0 || out_valid || in_valid) && cyc < 20) begin
            acc = in_valid && in_ready;
            tick(got, had, o, e);
            if (got) begin
                n_out++;
                n_run++;
                if (!had || o !== e) begin
                    n_fail++;
                    $display("FAIL %s_out: got %h expected %h (expected present=%0d)", name, o, e, had);
                end
            end
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        n_run++;
        if (expq.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d bundles left, out_valid=%b after %0d cycles", name, expq.size(), out_valid, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        n_run++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_hs: valid/ready %b required 01", {out_valid, in_ready});
        end
        n_run++;
        if (observe() !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0", observe());
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_addi();
        bit   got, had;
        obs_t o, e;
        int   n;
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h100;
        tick(got, had, o, e);
        in_valid = 1'b0;
        n_run++;
        if ({out_valid, out_rd, out_rs1, out_funct3, out_fmt, out_imm, out_pc, out_illegal} !==
            {1'b1, 5'd1, 5'd2, 3'd0, 3'd1, 32'hFFFFFFFF, 32'h100, 1'b0}) begin
            n_fail++;
            $display("FAIL addi: v=%b rd=%0d rs1=%0d f3=%0d fmt=%0d imm=%h pc=%h ill=%b required 1/1/2/0/1/ffffffff/100/0",
                     out_valid, out_rd, out_rs1, out_funct3, out_fmt, out_imm, out_pc, out_illegal);
        end
        drain("addi", n);
    endtask

    task automatic test_back_to_back();
        bit          got, had;
        obs_t        o, e;
        int          n;
        logic [31:0] words [0:2];
        logic [44:0] want  [0:2];
        words = '{32'h00512423, 32'hFE000EE3, 32'h123451B7};
        want  = '{{3'd2, 5'd5, 5'd0, 32'h00000008},
                  {3'd3, 5'd0, 5'd0, 32'hFFFFFFFC},
                  {3'd4, 5'd0, 5'd3, 32'h12345000}};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_instr = words[i]; in_pc = 32'h200 + 32'(i * 4);
            tick(got, had, o, e);
            if (got) begin
                n_run++;
                if (!had || o !== e) begin
                    n_fail++;
                    $display("FAIL b2b_out%0d: got %h expected %h", i, o, e);
                end
            end
            n_run++;
            if (!out_valid || {out_fmt, (i == 0) ? out_rs2 : 5'd0, (i == 2) ? out_rd : 5'd0, out_imm} !== want[i]) begin
                n_fail++;
                $display("FAIL b2b_%0d: v=%b fmt=%0d rs2=%0d rd=%0d imm=%h required %h",
                         i, out_valid, out_fmt, out_rs2, out_rd, out_imm, want[i]);
            end
        end
        in_valid = 1'b0;
        drain("b2b", n);
    endtask

    task automatic test_illegal();
        bit          got, had;
        obs_t        o, e;
        int          n;
        logic [31:0] words [0:1];
        words = '{32'h00000000, 32'h0000007F};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_instr = words[i]; in_pc = 32'h300 + 32'(i * 4);
            tick(got, had, o, e);
            if (got) begin
                n_run++;
                if (!had || o !== e) begin
                    n_fail++;
                    $display("FAIL illegal_out%0d: got %h expected %h", i, o, e);
                end
            end
            n_run++;
            if ({out_valid, out_illegal, out_fmt, out_imm} !== {1'b1, 1'b1, 3'd7, 32'd0}) begin
                n_fail++;
                $display("FAIL illegal_%0d: v=%b ill=%b fmt=%0d imm=%h required 1/1/7/0",
                         i, out_valid, out_illegal, out_fmt, out_imm);
            end
        end
        in_valid = 1'b0;
        drain("illegal", n);
    endtask

    task automatic test_backpressure();
        bit          got, had;
        obs_t        o, e, head;
        int          n;
        logic [31:0] a;
        out_ready = 1'b0;
        a = 32'h00A00093;
        in_valid = 1'b1; in_instr = a; in_pc = 32'h400;
        tick(got, had, o, e);
        in_instr = 32'h00B00113; in_pc = 32'h404;
        tick(got, had, o, e);
        head = observe();
        n_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || head.instr !== a) begin
            n_fail++;
            $display("FAIL bp_full: in_ready=%b out_valid=%b head=%h required 0/1/%h", in_ready, out_valid, head.instr, a);
        end
        in_instr = 32'h00C00193; in_pc = 32'h408;
        for (int i = 0; i < 2; i++) begin
            tick(got, had, o, e);
            n_run++;
            if (in_ready !== 1'b0 || observe() !== head) begin
                n_fail++;
                $display("FAIL bp_hold%0d: in_ready=%b head=%h required 0/%h", i, in_ready, observe(), head);
            end
        end
        drain("bp", n);
        n_run++;
        if (n != 3) begin
            n_fail++;
            $display("FAIL bp_count: %0d bundles out required 3", n);
        end
    endtask

    task automatic test_flush();
        bit   got, had;
        obs_t o, e;
        int   n;
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h500;
        tick(got, had, o, e);
        in_instr = 32'h00200113; in_pc = 32'h504;
        tick(got, had, o, e);
        n_run++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_two: in_ready=%b required 0", in_ready);
        end
        flush = 1'b1; in_instr = 32'h00300193; in_pc = 32'h508;
        tick(got, had, o, e);
        flush = 1'b0; in_valid = 1'b0;
        n_run++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_two_after: valid/ready %b required 01", {out_valid, in_ready});
        end
        drain("flush_two", n);
        n_run++;
        if (n != 0) begin
            n_fail++;
            $display("FAIL flush_two_leak: %0d bundles out required 0", n);
        end
        // Flush from ONE with an acceptable incoming instruction.
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00400213; in_pc = 32'h50C;
        tick(got, had, o, e);
        flush = 1'b1; in_instr = 32'h00500293; in_pc = 32'h510;
        tick(got, had, o, e);
        flush = 1'b0; in_valid = 1'b0;
        n_run++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_one_after: valid/ready %b required 01", {out_valid, in_ready});
        end
        drain("flush_one", n);
        n_run++;
        if (n != 0) begin
            n_fail++;
            $display("FAIL flush_one_leak: %0d bundles out required 0", n);
        end
    endtask

    task automatic test_async_reset();
        bit   got, had;
        obs_t o, e;
        int   n;
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 32'h600;
        tick(got, had, o, e);
        in_instr = 32'h123451B7; in_pc = 32'h604;
        tick(got, had, o, e);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_run++;
        if ({out_valid, in_ready} !== 2'b01 || observe() !== '0) begin
            n_fail++;
            $display("FAIL async_reset: valid/ready %b data %h required 01 and 0", {out_valid, in_ready}, observe());
        end
        expq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        drain("async_reset", n);
        n_run++;
        if (n != 0) begin
            n_fail++;
            $display("FAIL async_reset_leak: %0d bundles out required 0", n);
        end
    endtask

    task automatic test_random(input int count);
        bit   got, had, acc;
        obs_t o, e;
        int   sent, guard, n;
        sent = 0; guard = 0;
        in_valid = 1'b0;
        while (sent < count && guard < 20000) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_instr = rand_instr();
                in_pc    = $urandom & 32'hFFFFFFFC;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            acc = in_valid && in_ready;
            tick(got, had, o, e);
            if (got) begin
                n_run++;
                if (!had || o !== e) begin
                    n_fail++;
                    $display("FAIL random_out: got %h expected %h (expected present=%0d)", o, e, had);
                end
            end
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
            guard++;
        end
        n_run++;
        if (sent != count) begin
            n_fail++;
            $display("FAIL random_stall: sent %0d of %0d", sent, count);
        end
        drain("random", n);
    endtask

`ifdef DECODE_STATS_EN
    task automatic test_stats();
        int          n;
        logic [31:0] words [0:4];
        words = '{32'h00100093, 32'h00000000, 32'h00512423, 32'h123451B7, 32'h00000067};
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        expq.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instr = words[i]; in_pc = 32'h700 + 32'(i * 4);
            drain("stats", n);
        end
        n_run++;
        if (stat_decoded !== 32'd5 || stat_illegal !== 32'd1) begin
            n_fail++;
            $display("FAIL stats: decoded=%0d illegal=%0d required 5/1", stat_decoded, stat_illegal);
        end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        n_run++;
        if (stat_decoded !== 32'd5 || stat_illegal !== 32'd1) begin
            n_fail++;
            $display("FAIL stats_flush: decoded=%0d illegal=%0d required 5/1", stat_decoded, stat_illegal);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_illegal();
        test_backpressure();
        test_flush();
        test_random(400);
        test_async_reset();
`ifdef DECODE_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
